// File: rtl/tilt_pkg.sv
// Shared tilt classification types and default tuning for the accelerometer filter
// and the spaceship position controller.
package tilt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      NEG  = 2'b01,
      POS  = 2'b10
   } tilt_t;

   localparam int DEF_AXIS_W   = 16;
   localparam int DEF_AVG_LOG2 = 2;
   localparam int DEF_ENTER_TH = 384;
   localparam int DEF_EXIT_TH  = 256;
   localparam int DEF_DWELL    = 3;

   // Width of a counter that must hold values 0..n.
   function automatic int count_width(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/accel_tilt_filter_if.sv
// Sample/result bundle between spi_control, the tilt filter and the position controller.
interface accel_tilt_filter_if #(
   parameter int AXIS_W = 16
);
   logic                     sample_en;
   logic signed [AXIS_W-1:0] data_x;
   logic signed [AXIS_W-1:0] data_y;
   logic signed [AXIS_W-1:0] filt_x;
   logic signed [AXIS_W-1:0] filt_y;
   logic [1:0]               tilt_x;
   logic [1:0]               tilt_y;
   logic                     valid;

   modport master (
      output sample_en, data_x, data_y,
      input  filt_x, filt_y, tilt_x, tilt_y, valid
   );

   modport slave (
      input  sample_en, data_x, data_y,
      output filt_x, filt_y, tilt_x, tilt_y, valid
   );
endinterface

// File: rtl/tilt_axis.sv
// One accelerometer axis: moving-average window, registered filter output and
// hysteresis/dwell tilt classifier.
module tilt_axis
   import tilt_pkg::*;
#(
   parameter int AXIS_W   = DEF_AXIS_W,
   parameter int AVG_LOG2 = DEF_AVG_LOG2,
   parameter int ENTER_TH = DEF_ENTER_TH,
   parameter int EXIT_TH  = DEF_EXIT_TH,
   parameter int DWELL    = DEF_DWELL
) (
   input  logic                     slowclk,
   input  logic                     reset_n,
   input  logic                     sample_en,
   input  logic [AVG_LOG2-1:0]      ptr,
   input  logic signed [AXIS_W-1:0] sample,
   input  logic                     filt_load,
   input  logic                     fsm_step,
   output logic signed [AXIS_W-1:0] filt,
   output tilt_t                    tilt
);

   localparam int WIN   = 1 << AVG_LOG2;
   localparam int SUM_W = AXIS_W + AVG_LOG2;
   localparam int CNT_W = count_width(DWELL);

   localparam logic signed [AXIS_W-1:0] ENTER_POS = AXIS_W'(ENTER_TH);
   localparam logic signed [AXIS_W-1:0] ENTER_NEG = AXIS_W'(-ENTER_TH);
   localparam logic signed [AXIS_W-1:0] EXIT_POS  = AXIS_W'(EXIT_TH);
   localparam logic signed [AXIS_W-1:0] EXIT_NEG  = AXIS_W'(-EXIT_TH);

   logic signed [AXIS_W-1:0] sample_buf [WIN];
   logic signed [SUM_W-1:0]  sum_q;
   logic signed [AXIS_W-1:0] filt_q;
   tilt_t                    state_q, state_d;
   logic [CNT_W-1:0]         pos_q, pos_d, neg_q, neg_d;

   // The sum is wide enough for WIN full-scale samples, so replacing the oldest never overflows.
   always_ff @(posedge slowclk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < WIN; i++) begin
            sample_buf[i] <= '0;
         end
         sum_q <= '0;
      end else if (sample_en) begin
         sum_q           <= sum_q - SUM_W'(sample_buf[ptr]) + SUM_W'(sample);
         sample_buf[ptr] <= sample;
      end
   end

   always_ff @(posedge slowclk or negedge reset_n) begin
      if (!reset_n) begin
         filt_q <= '0;
      end else if (filt_load) begin
         filt_q <= AXIS_W'(sum_q >>> AVG_LOG2);
      end
   end

   always_ff @(posedge slowclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         pos_q   <= '0;
         neg_q   <= '0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         neg_q   <= neg_d;
      end
   end

   // Leaving POS/NEG is immediate, so a sign reversal always spends at least one step in IDLE.
   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      neg_d   = neg_q;
      if (fsm_step) begin
         case (state_q)
            IDLE: begin
               if (filt_q >= ENTER_POS) begin
                  neg_d = '0;
                  if (pos_q == CNT_W'(DWELL - 1)) begin
                     state_d = POS;
                     pos_d   = '0;
                  end else begin
                     pos_d = pos_q + CNT_W'(1);
                  end
               end else if (filt_q <= ENTER_NEG) begin
                  pos_d = '0;
                  if (neg_q == CNT_W'(DWELL - 1)) begin
                     state_d = NEG;
                     neg_d   = '0;
                  end else begin
                     neg_d = neg_q + CNT_W'(1);
                  end
               end else begin
                  pos_d = '0;
                  neg_d = '0;
               end
            end
            POS: begin
               if (filt_q < EXIT_POS) begin
                  state_d = IDLE;
               end
            end
            NEG: begin
               if (filt_q > EXIT_NEG) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
               pos_d   = '0;
               neg_d   = '0;
            end
         endcase
      end
   end

   assign filt = filt_q;
   assign tilt = state_q;

endmodule

// File: rtl/accel_tilt_filter.sv
// Two-axis accelerometer conditioning: shared window pointer, fill tracking and the
// sample -> filter -> classify pipeline strobes driving one tilt_axis per axis.
module accel_tilt_filter
   import tilt_pkg::*;
#(
   parameter int AXIS_W   = DEF_AXIS_W,
   parameter int AVG_LOG2 = DEF_AVG_LOG2,
   parameter int ENTER_TH = DEF_ENTER_TH,
   parameter int EXIT_TH  = DEF_EXIT_TH,
   parameter int DWELL    = DEF_DWELL
) (
   input  logic               slowclk,
   input  logic               reset_n,
   accel_tilt_filter_if.slave bus
);

   localparam int WIN    = 1 << AVG_LOG2;
   localparam int FILL_W = AVG_LOG2 + 1;

   logic [AVG_LOG2-1:0] ptr_q;
   logic [FILL_W-1:0]   fill_q;
   logic                samp_d1;
   logic                full_d1;
   logic                step_q;
   logic                valid_q;
   tilt_t               tilt_x;
   tilt_t               tilt_y;

   // full_d1 marks samples whose window is complete; only those may move the classifiers.
   always_ff @(posedge slowclk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q   <= '0;
         fill_q  <= '0;
         samp_d1 <= 1'b0;
         full_d1 <= 1'b0;
         step_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         samp_d1 <= bus.sample_en;
         full_d1 <= bus.sample_en && (fill_q >= FILL_W'(WIN - 1));
         step_q  <= samp_d1 && full_d1;
         if (step_q) begin
            valid_q <= 1'b1;
         end
         if (bus.sample_en) begin
            ptr_q <= ptr_q + AVG_LOG2'(1);
            if (fill_q != FILL_W'(WIN)) begin
               fill_q <= fill_q + FILL_W'(1);
            end
         end
      end
   end

   tilt_axis #(
      .AXIS_W   (AXIS_W),
      .AVG_LOG2 (AVG_LOG2),
      .ENTER_TH (ENTER_TH),
      .EXIT_TH  (EXIT_TH),
      .DWELL    (DWELL)
   ) axis_x (
      .slowclk   (slowclk),
      .reset_n   (reset_n),
      .sample_en (bus.sample_en),
      .ptr       (ptr_q),
      .sample    (bus.data_x),
      .filt_load (samp_d1),
      .fsm_step  (step_q),
      .filt      (bus.filt_x),
      .tilt      (tilt_x)
   );

   tilt_axis #(
      .AXIS_W   (AXIS_W),
      .AVG_LOG2 (AVG_LOG2),
      .ENTER_TH (ENTER_TH),
      .EXIT_TH  (EXIT_TH),
      .DWELL    (DWELL)
   ) axis_y (
      .slowclk   (slowclk),
      .reset_n   (reset_n),
      .sample_en (bus.sample_en),
      .ptr       (ptr_q),
      .sample    (bus.data_y),
      .filt_load (samp_d1),
      .fsm_step  (step_q),
      .filt      (bus.filt_y),
      .tilt      (tilt_y)
   );

   assign bus.tilt_x = tilt_x;
   assign bus.tilt_y = tilt_y;
   assign bus.valid  = valid_q;

endmodule

// File: tb/tb_accel_tilt_filter.sv
// Scoreboard bench for accel_tilt_filter: directed scenarios plus random levels,
// checked against a window/threshold model of the axis behaviour.
module tb_accel_tilt_filter;
   import tilt_pkg::*;

   localparam int AXIS_W   = 16;
   localparam int AVG_LOG2 = 2;
   localparam int WIN      = 4;
   localparam int ENTER_TH = 384;
   localparam int EXIT_TH  = 256;
   localparam int DWELL    = 3;

   logic slowclk = 1'b0;
   logic reset_n;

   always #5 slowclk = ~slowclk;

   accel_tilt_filter_if #(.AXIS_W(AXIS_W)) bus ();

   accel_tilt_filter #(
      .AXIS_W   (AXIS_W),
      .AVG_LOG2 (AVG_LOG2),
      .ENTER_TH (ENTER_TH),
      .EXIT_TH  (EXIT_TH),
      .DWELL    (DWELL)
   ) dut (
      .slowclk (slowclk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      int fx;
      int fy;
   } filt_exp_t;

   typedef struct {
      int tx;
      int ty;
      int v;
   } tilt_exp_t;

   filt_exp_t filt_exp_q[$];
   tilt_exp_t tilt_exp_q[$];

   int checks = 0;
   int passes = 0;

   // Reference model: last WIN samples per axis, fill count, tilt code (0 idle, 1 neg, 2 pos), dwell counts.
   int win_m   [2][WIN];
   int fill_m;
   int state_m [2];
   int pos_m   [2];
   int neg_m   [2];

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected) passes++;
      else $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
   endtask

   function automatic int floorAvg(input int s);
      if (s >= 0) return s / WIN;
      return -((-s + WIN - 1) / WIN);
   endfunction

   task automatic modelReset();
      for (int a = 0; a < 2; a++) begin
         for (int k = 0; k < WIN; k++) win_m[a][k] = 0;
         state_m[a] = 0;
         pos_m[a]   = 0;
         neg_m[a]   = 0;
      end
      fill_m = 0;
   endtask

   task automatic stepAxis(input int a, input int f);
      if (fill_m < WIN) return;
      case (state_m[a])
         0: begin
            if (f >= ENTER_TH) begin
               neg_m[a] = 0;
               pos_m[a]++;
               if (pos_m[a] == DWELL) begin
                  state_m[a] = 2;
                  pos_m[a]   = 0;
               end
            end else if (f <= -ENTER_TH) begin
               pos_m[a] = 0;
               neg_m[a]++;
               if (neg_m[a] == DWELL) begin
                  state_m[a] = 1;
                  neg_m[a]   = 0;
               end
            end else begin
               pos_m[a] = 0;
               neg_m[a] = 0;
            end
         end
         2: if (f < EXIT_TH) state_m[a] = 0;
         1: if (f > -EXIT_TH) state_m[a] = 0;
         default: state_m[a] = 0;
      endcase
   endtask

   // Drives one sample for one clock and queues what the outputs must show for it.
   task automatic applyStimulus(input int x, input int y);
      int        smp [2];
      int        f   [2];
      int        sum;
      filt_exp_t fe;
      tilt_exp_t te;
      smp[0] = x;
      smp[1] = y;
      if (fill_m < WIN) fill_m++;
      for (int a = 0; a < 2; a++) begin
         for (int k = 0; k < WIN - 1; k++) win_m[a][k] = win_m[a][k+1];
         win_m[a][WIN-1] = smp[a];
         sum = 0;
         for (int k = 0; k < WIN; k++) sum += win_m[a][k];
         f[a] = floorAvg(sum);
         stepAxis(a, f[a]);
      end
      fe.fx = f[0];
      fe.fy = f[1];
      te.tx = state_m[0];
      te.ty = state_m[1];
      te.v  = (fill_m >= WIN) ? 1 : 0;
      filt_exp_q.push_back(fe);
      tilt_exp_q.push_back(te);
      bus.sample_en = 1'b1;
      bus.data_x    = AXIS_W'(x);
      bus.data_y    = AXIS_W'(y);
      @(posedge slowclk);
      #1;
      bus.sample_en = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge slowclk);
         #1;
      end
   endtask

   task automatic repeatSample(input int x, input int y, input int n);
      for (int i = 0; i < n; i++) applyStimulus(x, y);
   endtask

   // Monitor: filt is due one edge after capture, tilt/valid two edges after.
   initial begin : monitor
      bit        c0, d1, d2;
      filt_exp_t fe;
      tilt_exp_t te;
      c0 = 0;
      d1 = 0;
      d2 = 0;
      forever begin
         @(posedge slowclk or negedge reset_n);
         if (!reset_n) begin
            c0 = 0;
            d1 = 0;
            d2 = 0;
         end else begin
            d2 = d1;
            d1 = c0;
            c0 = bus.sample_en;
            #1;
            if (d1) begin
               if (filt_exp_q.size() == 0) begin
                  checkOutput("filt_queue_underflow", 0, 1);
               end else begin
                  fe = filt_exp_q.pop_front();
                  checkOutput("filt_x", int'(bus.filt_x), fe.fx);
                  checkOutput("filt_y", int'(bus.filt_y), fe.fy);
               end
            end
            if (d2) begin
               if (tilt_exp_q.size() == 0) begin
                  checkOutput("tilt_queue_underflow", 0, 1);
               end else begin
                  te = tilt_exp_q.pop_front();
                  checkOutput("tilt_x", int'(bus.tilt_x), te.tx);
                  checkOutput("tilt_y", int'(bus.tilt_y), te.ty);
                  checkOutput("valid", int'(bus.valid), te.v);
               end
            end
         end
      end
   end

   initial begin : stimulus
      int               lx, ly, hold;
      logic signed [15:0] r;
      reset_n       = 1'b0;
      bus.sample_en = 1'b0;
      bus.data_x    = '0;
      bus.data_y    = '0;
      modelReset();
      idleCycles(3);
      checkOutput("reset_filt_x", int'(bus.filt_x), 0);
      checkOutput("reset_filt_y", int'(bus.filt_y), 0);
      checkOutput("reset_tilt_x", int'(bus.tilt_x), 0);
      checkOutput("reset_tilt_y", int'(bus.tilt_y), 0);
      checkOutput("reset_valid", int'(bus.valid), 0);
      @(negedge slowclk);
      reset_n = 1'b1;
      @(posedge slowclk);
      #1;

      $display("[TB] fill and valid");
      repeatSample(0, 0, 4);

      $display("[TB] enter with dwell");
      repeatSample(500, 0, 8);

      $display("[TB] hysteresis");
      repeatSample(300, 0, 6);
      repeatSample(200, 0, 6);

      $display("[TB] reversal through idle");
      repeatSample(500, 0, 8);
      repeatSample(-600, 0, 10);

      $display("[TB] floor toward minus infinity with gaps");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0);
         idleCycles(2);
      end
      applyStimulus(-1, 1);
      idleCycles(3);

      $display("[TB] dwell interruption");
      applyStimulus(2000, 0);
      applyStimulus(0, 0);
      applyStimulus(-2000, 0);
      applyStimulus(2000, 0);
      applyStimulus(2000, 0);
      applyStimulus(-2000, 0);
      applyStimulus(-2000, 0);
      applyStimulus(2000, 0);
      repeatSample(0, 0, 4);

      $display("[TB] random levels");
      hold = 0;
      lx   = 0;
      ly   = 0;
      for (int i = 0; i < 250; i++) begin
         if (hold == 0) begin
            if ($urandom_range(0, 7) == 0) begin
               r  = 16'($urandom);
               lx = int'(r);
            end else begin
               lx = int'($urandom_range(0, 1600)) - 800;
            end
            if ($urandom_range(0, 7) == 0) begin
               r  = 16'($urandom);
               ly = int'(r);
            end else begin
               ly = int'($urandom_range(0, 1600)) - 800;
            end
            hold = int'($urandom_range(1, 6));
         end
         hold--;
         if ($urandom_range(0, 3) == 0) idleCycles(int'($urandom_range(1, 2)));
         applyStimulus(lx, ly);
      end

      $display("[TB] reset mid-operation");
      repeatSample(500, -500, 10);
      idleCycles(3);
      checkOutput("pre_reset_tilt_x", int'(bus.tilt_x), state_m[0]);
      @(negedge slowclk);
      reset_n = 1'b0;
      #1;
      checkOutput("midreset_filt_x", int'(bus.filt_x), 0);
      checkOutput("midreset_filt_y", int'(bus.filt_y), 0);
      checkOutput("midreset_tilt_x", int'(bus.tilt_x), 0);
      checkOutput("midreset_tilt_y", int'(bus.tilt_y), 0);
      checkOutput("midreset_valid", int'(bus.valid), 0);
      modelReset();
      @(posedge slowclk);
      @(negedge slowclk);
      reset_n = 1'b1;
      @(posedge slowclk);
      #1;
      repeatSample(0, 0, 3);
      repeatSample(500, 500, 8);
      idleCycles(4);

      checkOutput("scoreboard_drained", filt_exp_q.size() + tilt_exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
